// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch with a one-entry skid buffer, flush-driven
//             response dropping and a delivered-instruction counter.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        fetch_stall,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        out_free;
    logic        load;
    logic [31:0] load_pc;
    logic [31:0] load_instr;

    assign out_free  = !if_valid_q || id_ready;
    assign imem_addr = {pc[31:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        hold_pc_d     = hold_pc_q;
        hold_instr_d  = hold_instr_q;
        fetch_count_d = fetch_count_q;
        fetch_stall   = 1'b1;
        imem_rmask    = 4'h0;
        load          = 1'b0;
        load_pc       = pc;
        load_instr    = imem_rdata;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_rmask = 4'hF;
                if (flush) begin
                    // An unanswered request must have its late response swallowed
                    state_d = imem_resp ? S_FETCH : S_DROP;
                end else if (imem_resp) begin
                    if (out_free) begin
                        load        = 1'b1;
                        fetch_stall = 1'b0;
                    end else begin
                        hold_pc_d    = pc;
                        hold_instr_d = imem_rdata;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_d = S_FETCH;
                end else if (id_ready) begin
                    load        = 1'b1;
                    load_pc     = hold_pc_q;
                    load_instr  = hold_instr_q;
                    fetch_stall = 1'b0;
                    state_d     = S_FETCH;
                end
            end
            S_DROP: begin
                if (!flush && imem_resp) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            fetch_stall = 1'b0;
            if_valid_d  = 1'b0;
            if_instr_d  = NOP_INSTR;
        end else if (load) begin
            if_valid_d    = 1'b1;
            if_pc_d       = load_pc;
            if_instr_d    = load_instr;
            fetch_count_d = fetch_count_q + 32'd1;
        end else if (if_valid_q && id_ready) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end

        // Reset holds the PC register and keeps the memory port idle
        if (!rst) begin
            fetch_stall = 1'b1;
            imem_rmask  = 4'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'd0;
            if_instr_q    <= NOP_INSTR;
            hold_pc_q     <= 32'd0;
            hold_instr_q  <= NOP_INSTR;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            hold_pc_q     <= hold_pc_d;
            hold_instr_q  <= hold_instr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_instr    = if_instr_q;
    assign fetch_count = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage: directed vector table,
//             counter wrap sequence and randomized run against a model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        flush;
    logic        fetch_stall;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_stage #(.NOP_INSTR(C_NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .flush       (flush),
        .fetch_stall (fetch_stall),
        .imem_addr   (imem_addr),
        .imem_rmask  (imem_rmask),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .fetch_count (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, flush, id_ready, resp;
        logic [31:0] pc, rdata;
        logic        exp_stall;
        logic [3:0]  exp_rmask;
        logic        exp_valid;
        logic [31:0] exp_pc, exp_instr, exp_count;
    } vec_t;

    vec_t tbl [18];

    // Behavioural reference for the random phase
    logic        m_started, m_holding, m_dropping;
    logic [31:0] m_hold_pc, m_hold_instr;
    logic        m_valid;
    logic [31:0] m_pc, m_instr, m_count;

    initial begin
        //            rst flush rdy resp pc             rdata          stall rmask valid if_pc          instr          count
        tbl[0]  = '{0, 0, 1, 0, 32'h6000_0000, 32'h0,          1, 4'h0, 0, 32'h0,          C_NOP,         32'd0};
        tbl[1]  = '{1, 0, 1, 0, 32'h6000_0000, 32'h0,          1, 4'h0, 0, 32'h0,          C_NOP,         32'd0};
        tbl[2]  = '{1, 0, 1, 0, 32'h6000_0000, 32'h0,          1, 4'hF, 0, 32'h0,          C_NOP,         32'd0};
        tbl[3]  = '{1, 0, 1, 1, 32'h6000_0000, 32'h0000_0093,  0, 4'hF, 1, 32'h6000_0000,  32'h0000_0093, 32'd1};
        tbl[4]  = '{1, 0, 0, 1, 32'h6000_0004, 32'h0010_0113,  1, 4'hF, 1, 32'h6000_0000,  32'h0000_0093, 32'd1};
        tbl[5]  = '{1, 0, 0, 0, 32'h6000_0004, 32'h0,          1, 4'h0, 1, 32'h6000_0000,  32'h0000_0093, 32'd1};
        tbl[6]  = '{1, 0, 1, 0, 32'h6000_0004, 32'h0,          0, 4'h0, 1, 32'h6000_0004,  32'h0010_0113, 32'd2};
        tbl[7]  = '{1, 0, 1, 0, 32'h6000_0008, 32'h0,          1, 4'hF, 0, 32'h0,          C_NOP,         32'd2};
        tbl[8]  = '{1, 1, 1, 0, 32'h6000_0008, 32'h0,          0, 4'hF, 0, 32'h0,          C_NOP,         32'd2};
        tbl[9]  = '{1, 0, 1, 1, 32'h6000_0100, 32'hDEAD_BEEF,  1, 4'h0, 0, 32'h0,          C_NOP,         32'd2};
        tbl[10] = '{1, 0, 1, 0, 32'h6000_0100, 32'h0,          1, 4'hF, 0, 32'h0,          C_NOP,         32'd2};
        tbl[11] = '{1, 1, 1, 1, 32'h6000_0100, 32'hBEEF_0001,  0, 4'hF, 0, 32'h0,          C_NOP,         32'd2};
        tbl[12] = '{1, 0, 1, 0, 32'h6000_0203, 32'h0,          1, 4'hF, 0, 32'h0,          C_NOP,         32'd2};
        tbl[13] = '{1, 0, 1, 1, 32'h6000_0203, 32'h0000_0011,  0, 4'hF, 1, 32'h6000_0203,  32'h0000_0011, 32'd3};
        tbl[14] = '{1, 0, 0, 1, 32'h6000_0204, 32'h0000_0022,  1, 4'hF, 1, 32'h6000_0203,  32'h0000_0011, 32'd3};
        tbl[15] = '{0, 0, 0, 0, 32'h6000_0204, 32'h0,          1, 4'h0, 0, 32'h0,          C_NOP,         32'd0};
        tbl[16] = '{1, 0, 1, 1, 32'h6000_0204, 32'h0000_0033,  1, 4'h0, 0, 32'h0,          C_NOP,         32'd0};
        tbl[17] = '{1, 0, 1, 0, 32'h6000_0204, 32'h0,          1, 4'hF, 0, 32'h0,          C_NOP,         32'd0};

        rst = 1'b0; flush = 1'b0; id_ready = 1'b0; imem_resp = 1'b0;
        pc = 32'h0; imem_rdata = 32'h0;
        @(posedge clk); #1;

        // Directed vectors: combinational outputs before the edge, registers after
        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst; flush = tbl[i].flush; id_ready = tbl[i].id_ready;
            imem_resp = tbl[i].resp; pc = tbl[i].pc; imem_rdata = tbl[i].rdata;
            #1;
            chk($sformatf("v%0d_stall", i), {31'd0, fetch_stall}, {31'd0, tbl[i].exp_stall});
            chk($sformatf("v%0d_rmask", i), {28'd0, imem_rmask}, {28'd0, tbl[i].exp_rmask});
            chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].pc & 32'hFFFF_FFFC);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].exp_valid});
            chk($sformatf("v%0d_instr", i), if_instr, tbl[i].exp_instr);
            chk($sformatf("v%0d_count", i), fetch_count, tbl[i].exp_count);
            if (tbl[i].exp_valid || !tbl[i].rst)
                chk($sformatf("v%0d_if_pc", i), if_pc, tbl[i].exp_pc);
        end

        // Counter wrap: preload all-ones, then one delivery
        rst = 1'b1; flush = 1'b0; id_ready = 1'b1; imem_resp = 1'b0; pc = 32'h6000_0300;
        force dut.fetch_count_d = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.fetch_count_d;
        #1;
        chk("wrap_preload", fetch_count, 32'hFFFF_FFFF);
        imem_resp = 1'b1; imem_rdata = 32'h0000_0777;
        #1;
        chk("wrap_stall", {31'd0, fetch_stall}, 32'd0);
        @(posedge clk); #1;
        chk("wrap_count", fetch_count, 32'd0);
        chk("wrap_valid", {31'd0, if_valid}, 32'd1);
        chk("wrap_instr", if_instr, 32'h0000_0777);

        // Randomized phase starting from a fresh reset
        rst = 1'b0; imem_resp = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        m_started = 0; m_holding = 0; m_dropping = 0;
        m_hold_pc = 0; m_hold_instr = 0;
        m_valid = 0; m_pc = 0; m_instr = C_NOP; m_count = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        e_stall, free, deliver;
            logic [3:0]  e_rmask;
            logic [31:0] d_pc, d_instr;
            rst        = ($urandom_range(0, 59) != 0);
            flush      = ($urandom_range(0, 7) == 0);
            imem_resp  = ($urandom_range(0, 1) == 1);
            id_ready   = ($urandom_range(0, 4) < 3);
            pc         = $urandom;
            imem_rdata = $urandom;

            free    = !m_valid || id_ready;
            e_rmask = (rst && m_started && !m_holding && !m_dropping) ? 4'hF : 4'h0;
            if (!rst)             e_stall = 1'b1;
            else if (flush)       e_stall = 1'b0;
            else if (!m_started)  e_stall = 1'b1;
            else if (m_holding)   e_stall = !id_ready;
            else if (m_dropping)  e_stall = 1'b1;
            else                  e_stall = !(imem_resp && free);

            #1;
            chk("rnd_stall", {31'd0, fetch_stall}, {31'd0, e_stall});
            chk("rnd_rmask", {28'd0, imem_rmask}, {28'd0, e_rmask});
            chk("rnd_addr", imem_addr, {pc[31:2], 2'b00});

            deliver = 1'b0; d_pc = 32'h0; d_instr = 32'h0;
            if (!rst) begin
                m_started = 0; m_holding = 0; m_dropping = 0;
                m_valid = 0; m_pc = 0; m_instr = C_NOP; m_count = 0;
            end else if (!m_started) begin
                m_started = 1;
            end else if (flush) begin
                m_dropping = m_dropping || (!m_holding && !imem_resp);
                m_holding  = 0;
                m_valid    = 0;
                m_instr    = C_NOP;
            end else begin
                if (m_holding) begin
                    if (id_ready) begin
                        deliver = 1; d_pc = m_hold_pc; d_instr = m_hold_instr;
                        m_holding = 0;
                    end
                end else if (m_dropping) begin
                    if (imem_resp) m_dropping = 0;
                end else if (imem_resp) begin
                    if (free) begin
                        deliver = 1; d_pc = pc; d_instr = imem_rdata;
                    end else begin
                        m_holding = 1; m_hold_pc = pc; m_hold_instr = imem_rdata;
                    end
                end
                if (deliver) begin
                    m_valid = 1; m_pc = d_pc; m_instr = d_instr; m_count = m_count + 1;
                end else if (m_valid && id_ready) begin
                    m_valid = 0; m_instr = C_NOP;
                end
            end

            @(posedge clk); #1;
            chk("rnd_valid", {31'd0, if_valid}, {31'd0, m_valid});
            chk("rnd_instr", if_instr, m_instr);
            chk("rnd_count", fetch_count, m_count);
            if (m_valid) chk("rnd_if_pc", if_pc, m_pc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: NOP_INSTR, default 32'h0000_0013, value driven on if_instr whenever if_valid=0.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset (rst=0 resets on the clock edge).
REQ-004 pc  input  32  current fetch PC from PC register.
REQ-005 flush  input  1  branch-mispredict redirect, same signal that redirects the PC register.
REQ-006 fetch_stall  output  1  holds the PC register when 1.
REQ-007 imem_addr  output  32  instruction memory word address.
REQ-008 imem_rmask  output  4  read byte mask; 4'hF = request, 4'h0 = idle.
REQ-009 imem_rdata  input  32  returned instruction word.
REQ-010 imem_resp  input  1  one-cycle response strobe qualifying imem_rdata.
REQ-011 id_ready  input  1  decode stage accepts the current if_* contents this cycle.
REQ-012 if_valid  output  1  registered instruction valid toward decode.
REQ-013 if_pc  output  32  registered PC of the delivered instruction.
REQ-014 if_instr  output  32  registered instruction word.
REQ-015 fetch_count  output  32  number of instructions delivered into the output register since reset.

Function
REQ-016 FSM states: IDLE, FETCH, HOLD, DROP; IDLE SHALL move to FETCH unconditionally after one cycle.
REQ-017 imem_addr SHALL equal {pc[31:2],2'b00} in every state; imem_rmask=4'hF in FETCH only, 4'h0 in IDLE, HOLD, DROP.
REQ-018 Output register "free" = !if_valid || id_ready.
REQ-019 FETCH, imem_resp=1, free, flush=0: load if_valid=1, if_pc=pc, if_instr=imem_rdata; fetch_stall=0 this cycle; stay FETCH; fetch_count+1.
REQ-020 FETCH, imem_resp=1, not free, flush=0: capture pc/rdata into a one-entry hold buffer; fetch_stall=1; go HOLD.
REQ-021 FETCH, imem_resp=0, flush=0: fetch_stall=1; request held stable; stay FETCH.
REQ-022 HOLD, id_ready=1, flush=0: move hold buffer into output register, fetch_stall=0, fetch_count+1, go FETCH; otherwise fetch_stall=1, stay HOLD.
REQ-023 No load and id_ready=1 with if_valid=1: if_valid SHALL clear next cycle.
REQ-024 fetch_stall SHALL be 0 whenever flush=1, in every state, so the PC register takes the redirect.
REQ-025 flush=1: if_valid and hold buffer cleared next cycle; no load, no fetch_count increment that cycle.
REQ-026 flush in FETCH with imem_resp=0: go DROP; flush in FETCH with imem_resp=1: discard rdata, stay FETCH; flush in HOLD or DROP: HOLD->FETCH, DROP stays DROP.
REQ-027 DROP: fetch_stall=1 (unless flush), no request; on imem_resp discard rdata and go FETCH.
REQ-028 imem_resp in IDLE or HOLD SHALL be ignored.
REQ-029 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-030 if_instr SHALL read NOP_INSTR whenever if_valid=0.

Reset
REQ-031 On rst=0 at clock edge: state=IDLE, if_valid=0, if_pc=0, if_instr=NOP_INSTR, hold buffer empty, fetch_count=0.
REQ-032 During reset and in IDLE: fetch_stall=1, imem_rmask=4'h0.
REQ-033 Reset mid-request (FETCH/DROP/HOLD) SHALL abandon the request; a later imem_resp in IDLE is ignored.

Verification
REQ-034 Reset release, pc=32'h6000_0000, imem_resp one cycle after request with 32'h0000_0093, id_ready=1 -> imem_addr=32'h6000_0000, then if_valid=1, if_pc=32'h6000_0000, if_instr=32'h0000_0093, fetch_count=1, fetch_stall low exactly in the response cycle.
REQ-035 Back-to-back responses, id_ready=0 on second -> HOLD, fetch_stall=1, output keeps first instruction; raise id_ready -> second delivered next cycle, fetch_count=2.
REQ-036 flush while request outstanding (pc=32'h6000_0008, redirect 32'h6000_0100) -> fetch_stall=0 that cycle, if_valid=0 next, late response discarded, next request addr=32'h6000_0100.
REQ-037 flush coincident with imem_resp -> rdata dropped, fetch_count unchanged, next request issued next cycle.
REQ-038 rst=0 while in HOLD -> if_valid=0, if_instr=32'h0000_0013, fetch_count=0, imem_rmask=0; stray imem_resp next cycle produces no output.
REQ-039 Preload fetch_count near 32'hFFFF_FFFF via 2^32-1 deliveries (or forced) -> next delivery yields 0.
